r4_digit_reverse_reorder: RTL

//  Output-reorder stage of the 5G NR IFFT chain; consumer of the last radix-4 SDF stage's serial stream.

---
 rtl/r4_digit_reverse_reorder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/r4_digit_reverse_reorder.sv
// Output reorder stage for the radix-4 SDF IFFT.
// Captures each frame in digit-reversed order into one bank of a ping-pong
// buffer. Frames are replayed from the other bank in natural order under
// valid/ready. The write side has no backpressure. If both banks are full,
// samples are dropped and the sticky overflow flag is set.
module r4_digit_reverse_reorder #(
  parameter int WIDTH = 26,
  parameter int N     = 2048,
  parameter int LOG2N = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    VALID,
  input  logic signed [WIDTH-1:0] data_in_r,
  input  logic signed [WIDTH-1:0] data_in_i,
  input  logic                    READY,
  output logic                    OUT_VALID,
  output logic signed [WIDTH-1:0] data_out_r,
  output logic signed [WIDTH-1:0] data_out_i,
  output logic                    frame_start,
  output logic                    frame_end,
  output logic                    overflow
);

  localparam int M = (LOG2N - 1) / 2;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  typedef enum logic {RD_IDLE = 1'b0, RD_RUN = 1'b1} rd_state_t;

  // The radix-4 digit pairs are mirrored end-for-end. The lone radix-2 digit
  // (the write-count MSB) lands in address bit 0.
  function automatic logic [LOG2N-1:0] digit_rev(input logic [LOG2N-1:0] w);
    logic [LOG2N-1:0] v;
    v = '0;
    for (int j = 0; j < M; j++) v[LOG2N-1-2*j -: 2] = w[2*j +: 2];
    v[0] = w[LOG2N-1];
    return v;
  endfunction

  logic [2*WIDTH-1:0]      r_mem [0:2*N-1];
  logic [LOG2N-1:0]        r_wcnt;
  logic [LOG2N-1:0]        r_rcnt;
  logic                    r_wr_bank;
  logic                    r_rd_bank;
  logic [1:0]              r_full;
  rd_state_t               r_state;
  logic                    r_out_valid;
  logic                    r_frame_start;
  logic                    r_frame_end;
  logic                    r_overflow;
  logic signed [WIDTH-1:0] r_dout_r;
  logic signed [WIDTH-1:0] r_dout_i;

  rd_state_t               w_state_nxt;
  logic [1:0]              w_full_nxt;
  logic [1:0]              w_set;
  logic [1:0]              w_clr;
  logic                    w_wr_en;
  logic                    w_drop;
  logic                    w_wr_last;
  logic                    w_adv;
  logic                    w_rd_last;
  logic                    w_rd_other;
  logic [2*WIDTH-1:0]      w_rd_data;

  assign w_wr_en    = VALID && !r_full[r_wr_bank];
  assign w_drop     = VALID && r_full[r_wr_bank];
  assign w_wr_last  = w_wr_en && (r_wcnt == LAST_IDX);
  assign w_adv      = (r_state == RD_RUN) && (!r_out_valid || READY);
  assign w_rd_last  = w_adv && (r_rcnt == LAST_IDX);
  assign w_rd_other = ~r_rd_bank;
  assign w_rd_data  = r_mem[{r_rd_bank, r_rcnt}];

  // Per-bank full flags: the writer sets and the reader clears.
  // The writer never targets a full bank, so a set and a clear cannot collide.
  always_comb begin
    w_set = 2'b00;
    w_clr = 2'b00;
    if (w_wr_last) w_set[r_wr_bank] = 1'b1;
    if (w_rd_last) w_clr[r_rd_bank] = 1'b1;
    w_full_nxt = (r_full & ~w_clr) | w_set;
  end

  // Read FSM next state. The lookahead on the flags lets a frame that
  // completes on the same edge follow without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_IDLE: if (r_full[r_rd_bank]) w_state_nxt = RD_RUN;
      RD_RUN:  if (w_rd_last && !w_full_nxt[w_rd_other]) w_state_nxt = RD_IDLE;
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // Sample storage, written at the digit-reversed address of the current bank.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[{r_wr_bank, digit_rev(r_wcnt)}] <= {data_in_r, data_in_i};
  end

  // Write counter, write bank select, full flags and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt     <= '0;
      r_wr_bank  <= 1'b0;
      r_full     <= 2'b00;
      r_overflow <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_en)   r_wcnt     <= r_wcnt + 1'b1;
      if (w_wr_last) r_wr_bank  <= ~r_wr_bank;
      if (w_drop)    r_overflow <= 1'b1;
    end
  end

  // Read state, read pointer and output register with frame markers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RD_IDLE;
      r_rcnt        <= '0;
      r_rd_bank     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_dout_r      <= '0;
      r_dout_i      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_adv) begin
        {r_dout_r, r_dout_i} <= w_rd_data;
        r_out_valid   <= 1'b1;
        r_frame_start <= (r_rcnt == '0);
        r_frame_end   <= (r_rcnt == LAST_IDX);
        r_rcnt        <= r_rcnt + 1'b1;
        if (w_rd_last) r_rd_bank <= ~r_rd_bank;
      end else if (r_out_valid && READY) begin
        r_out_valid   <= 1'b0;
        r_frame_start <= 1'b0;
        r_frame_end   <= 1'b0;
      end
    end
  end

  assign OUT_VALID   = r_out_valid;
  assign data_out_r  = r_dout_r;
  assign data_out_i  = r_dout_i;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
  assign overflow    = r_overflow;

endmodule
